// File: rtl/reduce_arbiter_if.sv
// reduce_arbiter_if: request/response bundle between requesters and the shared
// AND/OR reduction unit.
//   req_valid/req_data/req_ready : per-requester request handshake (one-hot ready)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_id/rsp_and/rsp_or        : result owner and reduction values
// master = requester/consumer side, slave = arbiter side.
interface reduce_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic                     rsp_and;
  logic                     rsp_or;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_and, rsp_or
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_and, rsp_or
  );
endinterface

// File: rtl/reduce_arbiter.sv
// reduce_arbiter: round-robin shares one registered 4-input AND/OR reduction
// among NUM_REQ requesters. A granted operand is captured in IDLE, reduced in
// EVAL and held on the response port in RESP until consumed.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : reduce_arbiter_if.slave request/response bundle
//   done_cnt   : completed responses, wraps modulo 2^CNT_W
//   busy       : high whenever a transaction is in flight (state != IDLE)
module reduce_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  reduce_arbiter_if.slave   bus,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              busy
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    win_q, win_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_and_q, rsp_and_d;
  logic               rsp_or_q, rsp_or_d;
  logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;

  logic [ID_W-1:0]    pick_c;
  logic               pick_found_c;
  logic [NUM_REQ-1:0] req_ready_c;
  int unsigned        scan_idx;

  // Round-robin pick: first valid requester scanning upward from ptr_q with wrap.
  always_comb begin
    pick_c       = '0;
    pick_found_c = 1'b0;
    scan_idx     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!pick_found_c && bus.req_valid[ID_W'(scan_idx)]) begin
        pick_c       = ID_W'(scan_idx);
        pick_found_c = 1'b1;
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    opnd_d      = opnd_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_and_d   = rsp_and_q;
    rsp_or_d    = rsp_or_q;
    done_cnt_d  = done_cnt_q;
    req_ready_c = '0;

    case (state_q)
      IDLE: begin
        if (pick_found_c) begin
          req_ready_c = NUM_REQ'(1) << pick_c;
          win_d       = pick_c;
          opnd_d      = bus.req_data[32'(pick_c)*WIDTH +: WIDTH];
          state_d     = EVAL;
        end
      end
      EVAL: begin
        rsp_and_d   = &opnd_q;
        rsp_or_d    = |opnd_q;
        rsp_id_d    = win_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          done_cnt_d  = done_cnt_q + CNT_W'(1);
          ptr_d       = (win_q == ID_W'(NUM_REQ - 1)) ? '0 : win_q + ID_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      opnd_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_and_q   <= 1'b0;
      rsp_or_q    <= 1'b0;
      done_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      opnd_q      <= opnd_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_and_q   <= rsp_and_d;
      rsp_or_q    <= rsp_or_d;
      done_cnt_q  <= done_cnt_d;
    end
  end

  // Grant is combinational; masked by reset so no requester sees an accept while held in reset.
  assign bus.req_ready = req_ready_c & {NUM_REQ{rst_n}};
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_and   = rsp_and_q;
  assign bus.rsp_or    = rsp_or_q;
  assign done_cnt      = done_cnt_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: doc/reduce_arbiter.md
# reduce_arbiter

Shares one registered 4-input AND/OR reduction unit among NUM_REQ requesters. It round-robin arbitrates valid/ready requests, captures the winning operand, evaluates the logical-AND and logical-OR reductions, and holds the result on a valid/ready response port until it is consumed. It sits between requester logic and the single reduction datapath, which replaces per-requester combinational reduction copies.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, operand bits reduced per request (b, c, d, e in LSB-first order)
- CNT_W, 16, width of completed-transaction counter

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_data  in  NUM_REQ*WIDTH  operand; requester i uses bits [i*WIDTH +: WIDTH]
- req_ready  out  NUM_REQ  one-hot accept; at most one bit set per cycle
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the result
- rsp_and  out  1  AND of all WIDTH operand bits
- rsp_or  out  1  OR of all WIDTH operand bits
- done_cnt  out  CNT_W  completed responses, wraps modulo 2^CNT_W
- busy  out  1  high when the FSM is not in IDLE

## Operation
- FSM states:
  - IDLE: arbitrate among req_valid. If any requester is valid, req_ready[winner]=1 combinationally (only for a requester whose req_valid is high), capture req_data[winner] and winner into internal registers, then go to EVAL. If no requester is valid, stay in IDLE.
  - EVAL: register rsp_and=&operand, rsp_or=|operand, rsp_id=winner, set rsp_valid, then go to RESP.
  - RESP: hold rsp_valid and all rsp_* outputs stable. When rsp_ready is high, clear rsp_valid, increment done_cnt, advance the round-robin pointer to (winner+1) mod NUM_REQ, and go to IDLE.
- Arbitration is round-robin. Priority starts at the pointer and scans upward with wrap. The pointer resets to 0 and advances only on response completion.
- req_ready is zero in EVAL and RESP. A requester must hold req_valid and req_data until accepted. Deasserting req_valid before acceptance withdraws the request; the block does not check this.
- rsp_and and rsp_or, together with rsp_id, change only on the EVAL→RESP edge. They keep their last values after the handshake.
- done_cnt wraps from 2^CNT_W−1 to 0 with no flag.
- busy = (state != IDLE).

## Timing
- Reset values: state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_and=0, rsp_or=0, done_cnt=0, pointer=0, busy=0.
- Request accepted at edge T (req_valid & req_ready in cycle T). rsp_valid is high after edge T+2, so it is visible in cycle T+2.
- Response handshake at cycle R (rsp_valid & rsp_ready). The FSM is in IDLE in cycle R+1, and the next request can be accepted in cycle R+1.
- Minimum issue interval is 3 cycles when rsp_ready is held high.
- Behaviour when rsp_ready is high before rsp_valid: no effect. The consumer may hold rsp_ready permanently high.
- Simultaneous requests: exactly one is granted per IDLE cycle. Other requesters see req_ready=0 and must keep requesting.
- A request that becomes valid in the cycle the FSM returns to IDLE is eligible in that same cycle.
- Reset asserted mid-transaction, in any state: all outputs immediately take their reset values. The in-flight transaction is dropped and not counted.

## Test plan
- Single request, NUM_REQ=4: req_valid=4'b0100, data[2]=4'b1111, rsp_ready=1 → req_ready=4'b0100 in cycle 0; in cycle 2 rsp_valid=1, rsp_id=2, rsp_and=1, rsp_or=1; done_cnt=1 afterwards.
- Operand coverage: data 4'b0000 → and=0, or=0; 4'b1000 → and=0, or=1; 4'b0111 → and=0, or=1; 4'b1111 → and=1, or=1.
- Round-robin fairness: all four requesters held valid, rsp_ready=1 → grants in order 0,1,2,3,0,… with one grant every 3 cycles; no requester is skipped across 12 grants.
- Backpressure: rsp_ready=0 for 10 cycles after rsp_valid rises → rsp_* outputs stable, req_ready=0 and busy=1 throughout; rsp_ready=1 → rsp_valid drops the next cycle and a pending request is accepted one cycle later.
- Async reset in RESP: assert rst_n=0 mid-cycle → rsp_valid=0 and busy=0 immediately with no clock edge; done_cnt=0; after release, the first grant goes to requester 0.
- Counter wrap with CNT_W=4: 17 completed transactions → done_cnt reads 15 after the 15th, 0 after the 16th, 1 after the 17th.
